instr_fifo: RTL and testbench

- Parametrised instruction queue that buffers decoded CISA instructions between the instruction issuer and one execution unit (DMA, arithmetic or cache).
- Accepts 1–4 instructions per cycle on the write side and delivers one instruction per cycle on the read side through a registered output.
- Provides early-warning full/empty flags so the issuer and the unit can throttle without a combinational round trip.
- Replaces the hardcoded program queues; one instance per unit, selected by WIDTH.

---
 rtl/cherry_pkg.sv | 29 ++
 rtl/instr_fifo_mem.sv | 59 +++++
 rtl/instr_fifo.sv | 99 +++++++++
 tb/tb_instr_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cherry_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cherry_pkg: shared CISA instruction widths and queue defaults. Rev 1.0
// -----------------------------------------------------------------------------
package cherry_pkg;

  localparam int CISA_DMA_W    = 78;
  localparam int CISA_ARITH_W  = 1;
  localparam int CISA_CACHE_W  = 17;
  localparam int INSTR_Q_DEPTH = 16;
  localparam int SOON          = 4;   // issuer burst size
  localparam int MAX_WR        = 4;   // write ports per cycle

  typedef enum logic [1:0] {
    UNIT_DMA   = 2'd0,
    UNIT_ARITH = 2'd1,
    UNIT_CACHE = 2'd2
  } unit_e;

  function automatic int instr_width(input unit_e unit);
    case (unit)
      UNIT_DMA:   return CISA_DMA_W;
      UNIT_ARITH: return CISA_ARITH_W;
      default:    return CISA_CACHE_W;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo_mem.sv
`default_nettype none
// -----------------------------------------------------------------------------
// instr_fifo_mem: DEPTHxWIDTH storage, 4 write ports at base+k, 1 sync read. Rev 1.0
// -----------------------------------------------------------------------------
module instr_fifo_mem
  import cherry_pkg::*;
#(
  parameter  int WIDTH = CISA_DMA_W,
  parameter  int DEPTH = INSTR_Q_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_cnt,
  input  logic [AW-1:0]    wr_base,
  input  logic [WIDTH-1:0] wr_data_1,
  input  logic [WIDTH-1:0] wr_data_2,
  input  logic [WIDTH-1:0] wr_data_3,
  input  logic [WIDTH-1:0] wr_data_4,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] w_wr_data [MAX_WR];
  logic [AW-1:0]    w_wr_addr [MAX_WR];
  logic             w_wr_sel  [MAX_WR];

  assign w_wr_data[0] = wr_data_1;
  assign w_wr_data[1] = wr_data_2;
  assign w_wr_data[2] = wr_data_3;
  assign w_wr_data[3] = wr_data_4;

  // Addresses wrap naturally in AW bits, so a burst may straddle the end.
  generate
    for (genvar k = 0; k < MAX_WR; k++) begin : g_wr_port
      assign w_wr_addr[k] = wr_base + AW'(k);
      assign w_wr_sel[k]  = wr_en && (wr_cnt >= 2'(k));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_WR; k++) begin
      if (w_wr_sel[k]) r_mem[w_wr_addr[k]] <= w_wr_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// instr_fifo: 1-4 writes / 1 registered read instruction queue with soon flags. Rev 1.0
// -----------------------------------------------------------------------------
module instr_fifo
  import cherry_pkg::*;
#(
  parameter  int WIDTH = CISA_DMA_W,
  parameter  int DEPTH = INSTR_Q_DEPTH,
  parameter  int SOON  = cherry_pkg::SOON,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re,
  input  logic             we,
  input  logic [1:0]       we_count,
  input  logic [WIDTH-1:0] dat_w_1,
  input  logic [WIDTH-1:0] dat_w_2,
  input  logic [WIDTH-1:0] dat_w_3,
  input  logic [WIDTH-1:0] dat_w_4,
  output logic [WIDTH-1:0] dat_r,
  output logic             dat_r_valid,
  output logic [CW-1:0]    count,
  output logic             full_soon,
  output logic             empty_soon,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_soon  = CW'(SOON);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic [CW-1:0] w_n;
  logic [CW-1:0] w_free;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Both accept decisions look only at the pre-cycle count.
  assign w_n      = CW'(we_count) + CW'(1);
  assign w_free   = c_depth - r_count;
  assign w_wr_acc = we && (w_free >= w_n);
  assign w_rd_acc = re && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(w_n);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (w_wr_acc ? w_n : '0) - (w_rd_acc ? CW'(1) : '0);
      r_valid <= w_rd_acc;
      if (we && !w_wr_acc)       r_overflow  <= 1'b1;
      if (re && r_count == '0)   r_underflow <= 1'b1;
    end
  end

  instr_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (w_wr_acc && !reset),
    .wr_cnt    (we_count),
    .wr_base   (r_wr_ptr),
    .wr_data_1 (dat_w_1),
    .wr_data_2 (dat_w_2),
    .wr_data_3 (dat_w_3),
    .wr_data_4 (dat_w_4),
    .rd_en     (w_rd_acc && !reset),
    .rd_addr   (r_rd_ptr),
    .rd_data   (dat_r)
  );

  assign dat_r_valid = r_valid;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign empty       = (r_count == '0);
  assign empty_soon  = (r_count <= c_soon);
  assign full_soon   = (w_free < c_soon);

endmodule
`default_nettype wire

// File: tb/tb_instr_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_instr_fifo: directed bench for instr_fifo with a queue-based reference model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_instr_fifo;

  localparam int W  = 17;
  localparam int D  = 8;
  localparam int S  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset, re, we;
  logic [1:0]    we_count;
  logic [W-1:0]  dat_w_1, dat_w_2, dat_w_3, dat_w_4;
  logic [W-1:0]  dat_r;
  logic          dat_r_valid, full_soon, empty_soon, empty, overflow, underflow;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fifo #(.WIDTH(W), .DEPTH(D), .SOON(S)) dut (
    .clk(clk), .reset(reset), .re(re), .we(we), .we_count(we_count),
    .dat_w_1(dat_w_1), .dat_w_2(dat_w_2), .dat_w_3(dat_w_3), .dat_w_4(dat_w_4),
    .dat_r(dat_r), .dat_r_valid(dat_r_valid), .count(count),
    .full_soon(full_soon), .empty_soon(empty_soon), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the sticky bits.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dat;
  bit           m_valid, m_ovf, m_unf, m_ready;

  always @(posedge clk) begin
    int pre, n;
    bit wacc;
    if (reset) begin
      q.delete();
      m_dat = '0; m_valid = 0; m_ovf = 0; m_unf = 0; m_ready = 1;
    end else if (m_ready) begin
      pre  = q.size();
      n    = int'(we_count) + 1;
      wacc = we && ((D - pre) >= n);
      m_valid = re && (pre > 0);
      if (m_valid) m_dat = q.pop_front();
      if (re && pre == 0) m_unf = 1;
      if (we && !wacc) m_ovf = 1;
      if (wacc) begin
        q.push_back(dat_w_1);
        if (n > 1) q.push_back(dat_w_2);
        if (n > 2) q.push_back(dat_w_3);
        if (n > 3) q.push_back(dat_w_4);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("dat_r",       32'(dat_r),       32'(m_dat));
      chk("dat_r_valid", 32'(dat_r_valid), 32'(m_valid));
      chk("count",       32'(count),       32'(q.size()));
      chk("empty",       32'(empty),       32'(q.size() == 0));
      chk("empty_soon",  32'(empty_soon),  32'(q.size() <= S));
      chk("full_soon",   32'(full_soon),   32'((D - q.size()) < S));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("underflow",   32'(underflow),   32'(m_unf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit r, input bit w, input logic [1:0] wc,
                       input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input logic [W-1:0] d3, input logic [W-1:0] d4);
    re = r; we = w; we_count = wc;
    dat_w_1 = d1; dat_w_2 = d2; dat_w_3 = d3; dat_w_4 = d4;
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1; re = 0; we = 0; we_count = '0;
    dat_w_1 = '0; dat_w_2 = '0; dat_w_3 = '0; dat_w_4 = '0;
    tick(); tick();
    reset = 0;

    // Reset state and read-on-empty
    chk("rst_empty",      32'(empty), 1);
    chk("rst_empty_soon", 32'(empty_soon), 1);
    chk("rst_full_soon",  32'(full_soon), 0);
    chk("rst_count",      32'(count), 0);
    chk("rst_dat_r",      32'(dat_r), 0);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("unf_set",        32'(underflow), 1);
    chk("unf_valid",      32'(dat_r_valid), 0);

    // Single writes then three reads
    drive(0, 1, 2'd0, 17'h0A0A, '0, '0, '0);
    drive(0, 1, 2'd0, 17'h0B0B, '0, '0, '0);
    drive(0, 1, 2'd0, 17'h0C0C, '0, '0, '0);
    chk("abc_count", 32'(count), 3);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("pop_A", 32'(dat_r), 32'h0A0A);
    chk("pop_A_valid", 32'(dat_r_valid), 1);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("pop_B", 32'(dat_r), 32'h0B0B);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("pop_C", 32'(dat_r), 32'h0C0C);
    idle();
    chk("abc_empty", 32'(empty), 1);
    chk("abc_hold", 32'(dat_r), 32'h0C0C);
    chk("abc_valid_low", 32'(dat_r_valid), 0);

    // Near-full and dropped write
    do_reset();
    drive(0, 1, 2'd3, 17'h101, 17'h102, 17'h103, 17'h104);
    drive(0, 1, 2'd2, 17'h105, 17'h106, 17'h107, 17'h1FF);
    chk("nf_count", 32'(count), 7);
    chk("nf_full_soon", 32'(full_soon), 1);
    drive(0, 1, 2'd1, 17'h1EE, 17'h1ED, '0, '0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 7);
    for (int i = 0; i < 8; i++) drive(1, 0, 2'd0, '0, '0, '0, '0);
    idle();

    // Wrap: wr_ptr at 6, then a 4-entry burst straddles the end
    do_reset();
    drive(0, 1, 2'd3, 17'h11, 17'h12, 17'h13, 17'h14);
    drive(0, 1, 2'd1, 17'h15, 17'h16, '0, '0);
    for (int i = 0; i < 6; i++) drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("wrap_pre_empty", 32'(empty), 1);
    drive(0, 1, 2'd3, 17'h1A0, 17'h1A1, 17'h1A2, 17'h1A3);
    chk("wrap_count", 32'(count), 4);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("wrap_W0", 32'(dat_r), 32'h1A0);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("wrap_W1", 32'(dat_r), 32'h1A1);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("wrap_W2", 32'(dat_r), 32'h1A2);
    drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("wrap_W3", 32'(dat_r), 32'h1A3);

    // Simultaneous read and write
    do_reset();
    drive(0, 1, 2'd3, 17'h21, 17'h22, 17'h23, 17'h24);
    drive(0, 1, 2'd3, 17'h25, 17'h26, 17'h27, 17'h28);
    chk("full_count", 32'(count), 8);
    chk("full_empty_soon", 32'(empty_soon), 0);
    drive(1, 1, 2'd0, 17'h29, '0, '0, '0);
    chk("sim_full_ovf", 32'(overflow), 1);
    chk("sim_full_count", 32'(count), 7);
    chk("sim_full_dat", 32'(dat_r), 32'h21);
    for (int i = 0; i < 3; i++) drive(1, 0, 2'd0, '0, '0, '0, '0);
    chk("sim4_pre", 32'(count), 4);
    drive(1, 1, 2'd3, 17'h31, 17'h32, 17'h33, 17'h34);
    chk("sim4_count", 32'(count), 7);

    // Reset mid-burst with a write pending
    do_reset();
    drive(0, 1, 2'd3, 17'h41, 17'h42, 17'h43, 17'h44);
    drive(0, 1, 2'd0, 17'h45, '0, '0, '0);
    drive(0, 1, 2'd3, 17'h46, 17'h47, 17'h48, 17'h49);
    chk("rm_count5", 32'(count), 5);
    chk("rm_ovf", 32'(overflow), 1);
    reset = 1;
    drive(0, 1, 2'd0, 17'h4A, '0, '0, '0);
    reset = 0;
    chk("rm_count0", 32'(count), 0);
    chk("rm_empty", 32'(empty), 1);
    chk("rm_ovf_clr", 32'(overflow), 0);
    idle();
    chk("rm_not_stored", 32'(count), 0);

    // Mixed traffic against the model
    for (int i = 0; i < 120; i++) begin
      drive((i % 2) == 0 || (i % 7) == 3, (i % 3) != 0, 2'(i % 4),
            17'(i * 4 + 1), 17'(i * 4 + 2), 17'(i * 4 + 3), 17'(i * 4 + 4));
    end
    for (int i = 0; i < 10; i++) drive(1, 0, 2'd0, '0, '0, '0, '0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
